// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (bios loader, CPU) and the arbiter,
// plus the arbiter's single RAM port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      p0_req;
  logic                      p0_we;
  logic [ADDR_WIDTH-1:0]     p0_addr;
  logic [DATA_WIDTH/8-1:0]   p0_be;
  logic [DATA_WIDTH-1:0]     p0_wdata;
  logic                      p0_gnt;
  logic                      p0_rvalid;
  logic [DATA_WIDTH-1:0]     p0_rdata;

  logic                      p1_req;
  logic                      p1_we;
  logic [ADDR_WIDTH-1:0]     p1_addr;
  logic [DATA_WIDTH/8-1:0]   p1_be;
  logic [DATA_WIDTH-1:0]     p1_wdata;
  logic                      p1_gnt;
  logic                      p1_rvalid;
  logic [DATA_WIDTH-1:0]     p1_rdata;

  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_be, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_be, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata
  );

  // Requester / RAM environment side
  modport master (
    output p0_req, p0_we, p0_addr, p0_be, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_be, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified RAM: bios-only until boot_done, then
// round-robin with a starvation guard; read data routed back via a tag pipeline.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_done,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_SAT = CNT_WIDTH'(MAX_WAIT);

  logic                  last_gnt;
  logic [CNT_WIDTH-1:0]  wait_cnt0;
  logic [CNT_WIDTH-1:0]  wait_cnt1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  starve0;
  logic                  starve1;
  logic                  accept;

  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [BE_WIDTH-1:0]   cmd_be;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Stage k holds the tag of the command that was on mem_en k cycles ago.
  logic [RD_LATENCY:0]   tag_valid;
  logic [RD_LATENCY:0]   tag_port;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    starve0 = bus.p0_req && (wait_cnt0 == WAIT_SAT);
    starve1 = bus.p1_req && (wait_cnt1 == WAIT_SAT);
    if (!boot_done) begin
      gnt0 = bus.p0_req;
    end else if (starve0) begin
      gnt0 = 1'b1;
    end else if (starve1) begin
      gnt1 = 1'b1;
    end else if (bus.p0_req && bus.p1_req) begin
      gnt0 = last_gnt;
      gnt1 = ~last_gnt;
    end else begin
      gnt0 = bus.p0_req;
      gnt1 = bus.p1_req;
    end
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;
  assign accept     = gnt0 | gnt1;

  always_comb begin
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_be    = '0;
    cmd_wdata = '0;
    if (gnt1) begin
      cmd_we    = bus.p1_we;
      cmd_addr  = bus.p1_addr;
      cmd_be    = bus.p1_be;
      cmd_wdata = bus.p1_wdata;
    end else begin
      cmd_we    = bus.p0_we;
      cmd_addr  = bus.p0_addr;
      cmd_be    = bus.p0_be;
      cmd_wdata = bus.p0_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      wait_cnt0 <= '0;
      wait_cnt1 <= '0;
    end else begin
      if (accept) begin
        last_gnt <= gnt1;
      end

      if (!bus.p0_req || gnt0) begin
        wait_cnt0 <= '0;
      end else if (wait_cnt0 != WAIT_SAT) begin
        wait_cnt0 <= wait_cnt0 + CNT_WIDTH'(1);
      end

      if (!boot_done || !bus.p1_req || gnt1) begin
        wait_cnt1 <= '0;
      end else if (wait_cnt1 != WAIT_SAT) begin
        wait_cnt1 <= wait_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM command
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= accept;
      bus.mem_we <= accept & cmd_we;
      if (accept) begin
        bus.mem_addr  <= cmd_addr;
        bus.mem_be    <= cmd_be;
        bus.mem_wdata <= cmd_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline and response routing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid <= {tag_valid[RD_LATENCY-1:0], accept & ~cmd_we};
      tag_port  <= {tag_port[RD_LATENCY-1:0], gnt1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      bus.p0_rvalid <= tag_valid[RD_LATENCY] & ~tag_port[RD_LATENCY];
      bus.p1_rvalid <= tag_valid[RD_LATENCY] &  tag_port[RD_LATENCY];
      if (tag_valid[RD_LATENCY] && !tag_port[RD_LATENCY]) begin
        bus.p0_rdata <= bus.mem_rdata;
      end
      if (tag_valid[RD_LATENCY] && tag_port[RD_LATENCY]) begin
        bus.p1_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bios phase, writes, boot_done edges,
// starvation guard, mid-operation reset and round-robin streaming.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned RDL = 1;
  localparam int unsigned MW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic boot_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LATENCY(RDL),
    .MAX_WAIT  (MW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .boot_done(boot_done),
    .bus      (bus)
  );

  // RAM model with one cycle read latency.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? rd_model(bus.mem_addr) : 32'h0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic        exp_port [6];
  logic [31:0] exp_addr [6];
  logic [31:0] p0_ptr;
  logic [31:0] p1_ptr;

  initial begin
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};

    rst = 1'b1;
    boot_done = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_be = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_be = '0; bus.p1_wdata = '0;
    tick;
    tick;

    // Reset state
    chk("rst_mem_en",    64'(bus.mem_en),    64'h0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'h0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'h0);
    chk("rst_mem_be",    64'(bus.mem_be),    64'h0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
    chk("rst_p0_rvalid", 64'(bus.p0_rvalid), 64'h0);
    chk("rst_p1_rvalid", 64'(bus.p1_rvalid), 64'h0);
    chk("rst_p0_rdata",  64'(bus.p0_rdata),  64'h0);
    chk("rst_p1_rdata",  64'(bus.p1_rdata),  64'h0);
    rst = 1'b0;
    tick;

    // Bios phase read: port 0 at 0x10, port 1 blocked
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h40;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h10;
    #1;
    chk("boot_p0_gnt", 64'(bus.p0_gnt), 64'h1);
    chk("boot_p1_gnt", 64'(bus.p1_gnt), 64'h0);
    tick;                                         // T+1
    bus.p0_req = 1'b0;
    #1;
    chk("boot_mem_en",   64'(bus.mem_en),   64'h1);
    chk("boot_mem_we",   64'(bus.mem_we),   64'h0);
    chk("boot_mem_addr", 64'(bus.mem_addr), 64'h10);
    chk("boot_p1_gnt_t1", 64'(bus.p1_gnt),  64'h0);
    tick;                                         // T+2
    chk("boot_mem_en_t2",  64'(bus.mem_en),    64'h0);
    chk("boot_p0_rv_t2",   64'(bus.p0_rvalid), 64'h0);
    chk("boot_p1_gnt_t2",  64'(bus.p1_gnt),    64'h0);
    tick;                                         // T+3
    chk("boot_p0_rvalid", 64'(bus.p0_rvalid), 64'h1);
    chk("boot_p0_rdata",  64'(bus.p0_rdata),  64'hDEADBEEF);
    chk("boot_p1_rvalid", 64'(bus.p1_rvalid), 64'h0);
    tick;                                         // T+4
    chk("boot_p0_rv_t4",   64'(bus.p0_rvalid), 64'h0);
    chk("boot_p0_rd_hold", 64'(bus.p0_rdata),  64'hDEADBEEF);

    // Port 0 byte-lane write
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h20;
    bus.p0_be = 4'b0100; bus.p0_wdata = 32'h00AB0000;
    #1;
    chk("wr_p0_gnt", 64'(bus.p0_gnt), 64'h1);
    tick;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0;
    #1;
    chk("wr_mem_en",    64'(bus.mem_en),    64'h1);
    chk("wr_mem_we",    64'(bus.mem_we),    64'h1);
    chk("wr_mem_addr",  64'(bus.mem_addr),  64'h20);
    chk("wr_mem_be",    64'(bus.mem_be),    64'h4);
    chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'h00AB0000);
    tick;
    chk("idle_mem_en",   64'(bus.mem_en),   64'h0);
    chk("idle_mem_we",   64'(bus.mem_we),   64'h0);
    chk("idle_mem_addr", 64'(bus.mem_addr), 64'h20);
    chk("idle_mem_be",   64'(bus.mem_be),   64'h4);
    tick;
    chk("wr_p0_rvalid", 64'(bus.p0_rvalid), 64'h0);
    chk("wr_p1_rvalid", 64'(bus.p1_rvalid), 64'h0);

    // boot_done rise: port 1 competes at once; fall next cycle blocks it again
    boot_done = 1'b1;                             // R
    #1;
    chk("rise_p1_gnt", 64'(bus.p1_gnt), 64'h1);
    chk("rise_p0_gnt", 64'(bus.p0_gnt), 64'h0);
    tick;                                         // R+1
    boot_done = 1'b0;
    bus.p1_addr = 32'h44;
    #1;
    chk("fall_p1_gnt_r1", 64'(bus.p1_gnt),   64'h0);
    chk("fall_mem_en",    64'(bus.mem_en),   64'h1);
    chk("fall_mem_addr",  64'(bus.mem_addr), 64'h40);
    tick;                                         // R+2
    chk("fall_p1_gnt_r2", 64'(bus.p1_gnt), 64'h0);
    tick;                                         // R+3
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h50;
    #1;
    chk("fall_p1_rvalid", 64'(bus.p1_rvalid), 64'h1);
    chk("fall_p1_rdata",  64'(bus.p1_rdata),  64'hC0DE0040);
    chk("fall_p0_rvalid", 64'(bus.p0_rvalid), 64'h0);
    chk("fall_p0_gnt",    64'(bus.p0_gnt),    64'h1);
    chk("fall_p1_gnt_r3", 64'(bus.p1_gnt),    64'h0);
    tick;                                         // R+4
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    #1;
    chk("fall_p1_rv_r4", 64'(bus.p1_rvalid), 64'h0);
    chk("fall_addr_r4",  64'(bus.mem_addr),  64'h50);
    tick;
    tick;                                         // R+6
    chk("fall_p0_rv_r6", 64'(bus.p0_rvalid), 64'h1);
    chk("fall_p0_rd_r6", 64'(bus.p0_rdata),  64'hC0DE0050);
    tick;

    // Starvation guard: last_gnt pinned so port 0 keeps losing
    boot_done = 1'b1;                             // S
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h60;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h70;
    force dut.last_gnt = 1'b0;
    #1;
    chk("stv_p0_gnt_s0", 64'(bus.p0_gnt), 64'h0);
    chk("stv_p1_gnt_s0", 64'(bus.p1_gnt), 64'h1);
    tick;                                         // S+1
    chk("stv_cnt_s1",    64'(dut.wait_cnt0), 64'h1);
    chk("stv_p0_gnt_s1", 64'(bus.p0_gnt),    64'h0);
    chk("stv_p1_gnt_s1", 64'(bus.p1_gnt),    64'h1);
    tick;                                         // S+2
    chk("stv_cnt_s2",    64'(dut.wait_cnt0), 64'h2);
    chk("stv_p0_gnt_s2", 64'(bus.p0_gnt),    64'h1);
    chk("stv_p1_gnt_s2", 64'(bus.p1_gnt),    64'h0);
    tick;                                         // S+3
    bus.p0_req = 1'b0;
    release dut.last_gnt;
    #1;
    chk("stv_cnt_clr",   64'(dut.wait_cnt0), 64'h0);
    chk("stv_p1_gnt_s3", 64'(bus.p1_gnt),    64'h1);
    tick;
    bus.p1_req = 1'b0;
    tick;
    tick;
    tick;
    tick;

    // Reset in the middle of an outstanding read
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h80;   // M
    #1;
    chk("mrst_p0_gnt", 64'(bus.p0_gnt), 64'h1);
    tick;                                         // M+1
    bus.p0_req = 1'b0;
    #1;
    chk("mrst_mem_en_pre", 64'(bus.mem_en), 64'h1);
    rst = 1'b1;
    #1;
    chk("mrst_mem_en",   64'(bus.mem_en),   64'h0);
    chk("mrst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("mrst_p0_rdata", 64'(bus.p0_rdata), 64'h0);
    chk("mrst_p1_rdata", 64'(bus.p1_rdata), 64'h0);
    tick;                                         // M+2
    rst = 1'b0;
    chk("mrst_rv_m2", 64'(bus.p0_rvalid), 64'h0);
    tick;                                         // M+3
    chk("mrst_rv_m3", 64'(bus.p0_rvalid), 64'h0);
    tick;                                         // M+4
    chk("mrst_rv_m4",    64'(bus.p0_rvalid), 64'h0);
    chk("mrst_p1_rv_m4", 64'(bus.p1_rvalid), 64'h0);

    // Round-robin stream: both ports read for 6 cycles, then drain
    p0_ptr = 32'h100;
    p1_ptr = 32'h200;
    for (int i = 0; i < 10; i++) begin
      bus.p0_req = (i < 6); bus.p0_we = 1'b0; bus.p0_addr = p0_ptr;
      bus.p1_req = (i < 6); bus.p1_we = 1'b0; bus.p1_addr = p1_ptr;
      #1;
      if (i < 6) begin
        chk($sformatf("rr_p0_gnt_%0d", i), 64'(bus.p0_gnt), 64'(exp_port[i] == 1'b0));
        chk($sformatf("rr_p1_gnt_%0d", i), 64'(bus.p1_gnt), 64'(exp_port[i] == 1'b1));
      end
      if (i >= 1 && i <= 6) begin
        chk($sformatf("rr_mem_en_%0d", i),   64'(bus.mem_en),   64'h1);
        chk($sformatf("rr_mem_addr_%0d", i), 64'(bus.mem_addr), 64'(exp_addr[i-1]));
      end else begin
        chk($sformatf("rr_mem_en_%0d", i), 64'(bus.mem_en), 64'h0);
      end
      if (i >= 3 && i <= 8) begin
        if (exp_port[i-3] == 1'b0) begin
          chk($sformatf("rr_p0_rv_%0d", i), 64'(bus.p0_rvalid), 64'h1);
          chk($sformatf("rr_p0_rd_%0d", i), 64'(bus.p0_rdata),  64'(32'hC0DE0000 | exp_addr[i-3]));
          chk($sformatf("rr_p1_rv_%0d", i), 64'(bus.p1_rvalid), 64'h0);
        end else begin
          chk($sformatf("rr_p1_rv_%0d", i), 64'(bus.p1_rvalid), 64'h1);
          chk($sformatf("rr_p1_rd_%0d", i), 64'(bus.p1_rdata),  64'(32'hC0DE0000 | exp_addr[i-3]));
          chk($sformatf("rr_p0_rv_%0d", i), 64'(bus.p0_rvalid), 64'h0);
        end
      end
      tick;
      if (i < 6) begin
        if (exp_port[i] == 1'b0) p0_ptr = p0_ptr + 32'h4;
        else                     p1_ptr = p1_ptr + 32'h4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified RAM port between two requesters: port 0 is the bios loader/monitor, port 1 is the CPU core.
- Until `boot_done` is asserted, only port 0 is served. After that, the ports are round-robin arbitrated, with a starvation guard.
- Issues at most one memory command per cycle, registered toward the RAM.
- Routes read data back to the port that issued the read, using a tag pipeline matched to the fixed RAM read latency.

Parameters:
- ADDR_WIDTH, 32: address width of both ports and the RAM side.
- DATA_WIDTH, 32: data width; byte enables are DATA_WIDTH/8 bits.
- RD_LATENCY, 1: cycles from `mem_en` (read) to valid `mem_rdata`; legal range 1..4.
- MAX_WAIT, 8: consecutive cycles a requester may be refused before it is forced to win.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- boot_done  in  1  0 = bios owns RAM, port 1 blocked; 1 = shared arbitration
- p0_req  in  1  port 0 command request; address, data and enables are held stable until granted
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  ADDR_WIDTH  byte address
- p0_be  in  DATA_WIDTH/8  byte enables (write only)
- p0_wdata  in  DATA_WIDTH  write data
- p0_gnt  out  1  combinational accept; the command is taken when p0_req and p0_gnt are both high
- p0_rvalid  out  1  one-cycle read-response strobe
- p0_rdata  out  DATA_WIDTH  read data, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_be, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for the CPU
- mem_en  out  1  RAM command strobe
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_be  out  DATA_WIDTH/8  RAM byte enables
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, RD_LATENCY cycles after a read `mem_en`

Behaviour:
- Reset values (asynchronous) and state cleared by reset:
  - All `mem_*` outputs, both `pN_rvalid` and both `pN_rdata` are 0.
  - `last_gnt` = 1, so port 0 has first priority.
  - Wait counters = 0; tag pipeline cleared.
  - Reset mid-operation drops any in-flight read: no `rvalid` is issued after reset.
- Grant (combinational from the `req` inputs and registered state; at most one grant per cycle):
  - `boot_done` = 0: `p0_gnt` = `p0_req`; `p1_gnt` = 0.
  - `boot_done` = 1, starvation check first:
    - If exactly one port is requesting and its wait counter equals MAX_WAIT, that port wins.
    - If both ports are starved, port 0 wins.
  - Otherwise, with both ports requesting: the port ≠ `last_gnt` wins.
  - With a single requester: that requester wins.
  - `last_gnt` updates to the granted port on every accept.
- Wait counters (width clog2(MAX_WAIT+1)):
  - Increment while `pN_req` & ~`pN_gnt`, saturating at MAX_WAIT.
  - Clear on accept or when `req` is low.
  - The port 1 counter is held at 0 while `boot_done` = 0.
- Command issue: on accept in cycle T, the `mem_*` registers load the accepted command at T+1.
  - `mem_en` = 1 for exactly one cycle per accept.
  - Back-to-back accepts give continuous `mem_en`; full throughput is 1 command/cycle.
- Read routing:
  - A tag pipeline of depth RD_LATENCY+1 carries {valid, port} for each issued read; writes push an invalid tag.
  - At T+1+RD_LATENCY, `mem_rdata` is sampled into the tagged port's `rdata` register.
  - That port's `rvalid` pulses at T+2+RD_LATENCY (RD_LATENCY=1: accept T, `rvalid` T+3).
  - The other port's `rvalid` stays 0.
  - `pN_rdata` holds its last value between responses.
- Writes: no response. `mem_we` = 1 and `mem_be`/`mem_wdata` are driven from the accepted command at T+1.
- boot_done transitions:
  - A fall (re-entry to bios) takes effect on the same-cycle grant.
  - Reads already in the tag pipeline still complete to their original port.
  - A rise lets port 1 compete in that same cycle.
- Idle: with no requests, `mem_en` = 0. `mem_addr`/`mem_wdata`/`mem_be` hold their last values; `mem_we` = 0.
- A requester dropping `req` before its grant is legal; nothing is issued for it.

Test Plan:
- Reset, then `boot_done`=0, `p1_req`=1 and `p0_req`=1 read at addr 0x10 with `mem_rdata`=0xDEADBEEF → `p1_gnt` stays 0; `p0_gnt`=1 at T; `mem_en` and `mem_addr`=0x10 at T+1; `p0_rvalid`=1 with `p0_rdata`=0xDEADBEEF at T+3; `p1_rvalid` stays 0.
- `boot_done`=1, both ports issue continuous reads for 6 cycles → grants alternate 0,1,0,1,0,1; `mem_en` high 6 consecutive cycles; each `rvalid`/`rdata` returns to the correct port in issue order.
- Port 0 writes addr 0x20, `be`=4'b0100, `wdata`=0x00AB0000 → at T+1: `mem_en`=1, `mem_we`=1, `mem_be`=4'b0100, `mem_wdata`=0x00AB0000; no `rvalid` on either port.
- MAX_WAIT=2, `boot_done`=1, port 1 continuously requesting while port 0 is held at the losing side artificially by forcing `last_gnt` → port 0 is granted no later than its 3rd refused cycle, and its counter clears to 0.
- Read from port 1 accepted, then `boot_done` falls the next cycle → that read's `p1_rvalid` still pulses at T+3; from the fall onward only port 0 is granted.
- Port 0 read accepted at T, `rst` asserted at T+1 for one cycle → all outputs are 0 immediately (asynchronous); no `p0_rvalid` pulse occurs afterward; the first post-reset grant with both ports requesting goes to port 0.
